// File: rtl/ram_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter_pkg : shared widths, FSM states and read-tag type.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 12
`endif
`ifndef DEPTH
`define DEPTH 2500
`endif

package ram_port_arbiter_pkg;

    localparam int RAM_DATA_WIDTH    = `DATA_WIDTH;
    localparam int RAM_ADDRESS_WIDTH = `ADDRESS_WIDTH;
    localparam int RAM_DEPTH         = `DEPTH;

    localparam int TAG_W = 1;

    typedef logic [TAG_W-1:0] req_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter; the requester not granted last wins.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie
    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        if (gnt_o[0]) begin
            last_d = 1'b0;
        end else if (gnt_o[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// ram_port_arbiter : two requesters with lock onto one registered RAM port.
// Optional address bounds check enabled by RAM_ARB_BOUNDS_CHECK_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 12
`endif
`ifndef DEPTH
`define DEPTH 2500
`endif

module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = `DATA_WIDTH,
    parameter int ADDRESS_WIDTH = `ADDRESS_WIDTH,
    parameter int DEPTH         = `DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    input  logic                     lock0,
    input  logic                     lock1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ram_we,
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    output logic                     err,
`endif
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

`ifdef RAM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    arb_state_e state_q;
    arb_state_e state_d;

    logic [1:0]               w_arb_req;
    logic [1:0]               w_arb_gnt;
    logic                     w_acc;
    logic                     w_sel1;
    logic [ADDRESS_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic                     w_we;
    logic                     w_oob;

    logic [ADDRESS_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0]    ram_wdata_q;
    logic                     ram_we_q;
    logic                     rd_v1_q;
    logic                     rd_v2_q;
    req_tag_t                 rd_tag1_q;
    req_tag_t                 rd_tag2_q;
    logic                     rd_oob1_q;
    logic                     rd_oob2_q;

    // While a requester owns the port the other one is hidden from the arbiter
    always_comb begin
        w_arb_req = {req1, req0};
        case (state_q)
            ST_OWN0: w_arb_req = {1'b0, req0};
            ST_OWN1: w_arb_req = {req1, 1'b0};
            default: w_arb_req = {req1, req0};
        endcase
    end

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (w_arb_req),
        .gnt_o (w_arb_gnt)
    );

    assign gnt0 = w_arb_gnt[0] & rst_n;
    assign gnt1 = w_arb_gnt[1] & rst_n;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt0 && lock0) begin
                    state_d = ST_OWN0;
                end else if (gnt1 && lock1) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0: if (!req0 || !lock0) state_d = ST_IDLE;
            ST_OWN1: if (!req1 || !lock1) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_acc   = gnt0 | gnt1;
    assign w_sel1  = gnt1;
    assign w_addr  = w_sel1 ? addr1  : addr0;
    assign w_wdata = w_sel1 ? wdata1 : wdata0;
    assign w_we    = w_sel1 ? we1    : we0;
    assign w_oob   = BOUNDS_EN && (32'(w_addr) >= 32'(DEPTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            rd_v1_q     <= 1'b0;
            rd_v2_q     <= 1'b0;
            rd_tag1_q   <= '0;
            rd_tag2_q   <= '0;
            rd_oob1_q   <= 1'b0;
            rd_oob2_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ram_we_q <= w_acc & w_we & ~w_oob;
            if (w_acc) begin
                ram_addr_q  <= w_addr;
                ram_wdata_q <= w_wdata;
            end
            // Stage 1 lines up with the RAM address, stage 2 with RAM data out
            rd_v1_q   <= w_acc & ~w_we;
            rd_tag1_q <= req_tag_t'(w_sel1);
            rd_oob1_q <= w_oob;
            rd_v2_q   <= rd_v1_q;
            rd_tag2_q <= rd_tag1_q;
            rd_oob2_q <= rd_oob1_q;
        end
    end

`ifdef RAM_ARB_BOUNDS_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= w_acc & w_oob;
        end
    end

    assign err = err_q;
`endif

    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_we    = ram_we_q;
    assign rvalid0   = rd_v2_q & (rd_tag2_q == req_tag_t'(0));
    assign rvalid1   = rd_v2_q & (rd_tag2_q == req_tag_t'(1));
    assign rdata     = rd_oob2_q ? '0 : ram_rdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_port_arbiter : directed and random checks against a behavioural model.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ram_port_arbiter;
    import ram_port_arbiter_pkg::*;

    localparam int DW    = RAM_DATA_WIDTH;
    localparam int AW    = RAM_ADDRESS_WIDTH;
    localparam int DEPTH = RAM_DEPTH;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic          lock0 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    logic          err;
`endif

    ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .lock0     (lock0),
        .lock1     (lock1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
`ifdef RAM_ARB_BOUNDS_CHECK_EN
        .err       (err),
`endif
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        if (i == 5) return DW'(16'h1234);
        return DW'(i * 40503 + 17);
    endfunction

    // RAM: synchronous write, registered read, contents restored while in reset
    logic [DW-1:0] mem [0:WORDS-1];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_val(i);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int            due;
        int            who;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t       rq[$];
    logic [DW-1:0] model_mem [0:WORDS-1];
    int            total = 0;
    int            bad = 0;
    int            edge_cnt = 0;
    int            owner = -1;
    int            last_g = 1;
    int            obs_g = -1;
    bit            exp_we = 1'b0;
    bit            exp_err = 1'b0;
    bit            addr_known = 1'b1;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0;

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) model_mem[i] = init_val(i);
        rq.delete();
        owner      = -1;
        last_g     = 1;
        exp_we     = 1'b0;
        exp_err    = 1'b0;
        addr_known = 1'b1;
        exp_addr   = '0;
    endtask

    // One clock: drive, check grant against the model, advance, check outputs
    task automatic run_cycle(input logic r0, input logic w0, input logic [AW-1:0] a0,
                             input logic [DW-1:0] d0, input logic l0,
                             input logic r1, input logic w1, input logic [AW-1:0] a1,
                             input logic [DW-1:0] d1, input logic l1);
        int            g;
        int            a;
        bit            w, lk, oob, want0, want1;
        logic [DW-1:0] d;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        #2;
        want0 = r0 && (owner != 1);
        want1 = r1 && (owner != 0);
        if (want0 && want1) g = (last_g == 0) ? 1 : 0;
        else if (want0)     g = 0;
        else if (want1)     g = 1;
        else                g = -1;
        obs_g = gnt0 ? 0 : (gnt1 ? 1 : -1);
        total++;
        if (gnt0 !== (g == 0) || gnt1 !== (g == 1)) begin
            bad++;
            $display("FAIL grant edge=%0d: gnt0=%b gnt1=%b, expected requester %0d", edge_cnt + 1, gnt0, gnt1, g);
        end
        exp_we  = 1'b0;
        exp_err = 1'b0;
        if (g >= 0) begin
            a   = (g == 1) ? int'(a1) : int'(a0);
            w   = (g == 1) ? w1 : w0;
            d   = (g == 1) ? d1 : d0;
            lk  = (g == 1) ? l1 : l0;
            oob = 1'b0;
`ifdef RAM_ARB_BOUNDS_CHECK_EN
            oob = (a >= DEPTH);
`endif
            addr_known = !oob;
            exp_addr   = AW'(a);
            exp_wdata  = d;
            exp_err    = oob;
            if (w) begin
                if (!oob) begin
                    exp_we       = 1'b1;
                    model_mem[a] = d;
                end
            end else begin
                rq.push_back('{edge_cnt + 2, g, (oob ? {DW{1'b0}} : model_mem[a])});
            end
            last_g = g;
            owner  = lk ? g : -1;
        end else begin
            owner = -1;
        end
        @(posedge clk);
        edge_cnt++;
        #1;
        total++;
        if (ram_we !== exp_we || (addr_known && ram_addr !== exp_addr) ||
            (exp_we && ram_wdata !== exp_wdata)) begin
            bad++;
            $display("FAIL ram_port edge=%0d: we=%b addr=%0d wdata=%h, expected we=%b addr=%0d wdata=%h",
                     edge_cnt, ram_we, ram_addr, ram_wdata, exp_we, exp_addr, exp_wdata);
        end
`ifdef RAM_ARB_BOUNDS_CHECK_EN
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL err edge=%0d: err=%b, expected %b", edge_cnt, err, exp_err);
        end
`endif
        total++;
        if (rq.size() > 0 && rq[0].due == edge_cnt) begin
            if (rvalid0 !== (rq[0].who == 0) || rvalid1 !== (rq[0].who == 1) || rdata !== rq[0].data) begin
                bad++;
                $display("FAIL read_return edge=%0d: rvalid0=%b rvalid1=%b rdata=%h, expected requester %0d data %h",
                         edge_cnt, rvalid0, rvalid1, rdata, rq[0].who, rq[0].data);
            end
            void'(rq.pop_front());
        end else if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            bad++;
            $display("FAIL spurious_rvalid edge=%0d: rvalid0=%b rvalid1=%b, expected 0 0", edge_cnt, rvalid0, rvalid1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) run_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_gnt: gnt0=%b gnt1=%b, expected 0 0", gnt0, gnt1);
        end
        total++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || ram_wdata !== '0) begin
            bad++;
            $display("FAIL reset_ram: we=%b addr=%h wdata=%h, expected all 0", ram_we, ram_addr, ram_wdata);
        end
        total++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_rvalid: rvalid0=%b rvalid1=%b, expected 0 0", rvalid0, rvalid1);
        end
        req0 = 1'b0; req1 = 1'b0;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        run_cycle(1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        total++;
        if (obs_g !== 0 || ram_addr !== AW'(5)) begin
            bad++;
            $display("FAIL single_read_issue: grant=%0d ram_addr=%0d, expected 0 and 5", obs_g, ram_addr);
        end
        idle(1);
        total++;
        if (rvalid0 !== 1'b1 || rdata !== DW'(16'h1234)) begin
            bad++;
            $display("FAIL single_read_data: rvalid0=%b rdata=%h, expected 1 and 1234", rvalid0, rdata);
        end
        idle(1);
    endtask

    task automatic test_alternate();
        int seq [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b1, 1'b0, AW'(i), '0, 1'b0, 1'b1, 1'b0, AW'(i + 8), '0, 1'b0);
            seq[i] = obs_g;
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seq[i] !== (i % 2)) begin
                bad++;
                $display("FAIL alternate[%0d]: granted %0d, expected %0d", i, seq[i], i % 2);
            end
        end
    endtask

    task automatic test_lock();
        int seq [4];
        do_reset();
        // lock0 is released together with the third grant
        run_cycle(1'b1, 1'b0, AW'(1), '0, 1'b1, 1'b1, 1'b0, AW'(2), '0, 1'b0); seq[0] = obs_g;
        run_cycle(1'b1, 1'b0, AW'(1), '0, 1'b1, 1'b1, 1'b0, AW'(2), '0, 1'b0); seq[1] = obs_g;
        run_cycle(1'b1, 1'b0, AW'(1), '0, 1'b0, 1'b1, 1'b0, AW'(2), '0, 1'b0); seq[2] = obs_g;
        run_cycle(1'b0, 1'b0, AW'(1), '0, 1'b0, 1'b1, 1'b0, AW'(2), '0, 1'b0); seq[3] = obs_g;
        idle(2);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (seq[i] !== ((i == 3) ? 1 : 0)) begin
                bad++;
                $display("FAIL lock[%0d]: granted %0d, expected %0d", i, seq[i], (i == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_raw();
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, AW'(10), DW'(16'hBEEF), 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, AW'(10), '0, 1'b0);
        idle(1);
        total++;
        if (rvalid1 !== 1'b1 || rdata !== DW'(16'hBEEF)) begin
            bad++;
            $display("FAIL raw: rvalid1=%b rdata=%h, expected 1 and beef", rvalid1, rdata);
        end
        idle(1);
    endtask

    task automatic test_bounds();
        logic [DW-1:0] want;
        run_cycle(1'b1, 1'b1, AW'(2600), DW'(16'h5A5A), 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
`ifdef RAM_ARB_BOUNDS_CHECK_EN
        want = '0;
        total++;
        if (obs_g !== 0 || ram_we !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL bounds_write: grant=%0d ram_we=%b err=%b, expected 0 0 1", obs_g, ram_we, err);
        end
`else
        want = DW'(16'h5A5A);
        total++;
        if (obs_g !== 0 || ram_we !== 1'b1 || ram_addr !== AW'(2600)) begin
            bad++;
            $display("FAIL bounds_write: grant=%0d ram_we=%b addr=%0d, expected 0 1 2600", obs_g, ram_we, ram_addr);
        end
`endif
        run_cycle(1'b1, 1'b0, AW'(2600), '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1);
        total++;
        if (rvalid0 !== 1'b1 || rdata !== want) begin
            bad++;
            $display("FAIL bounds_read: rvalid0=%b rdata=%h, expected 1 and %h", rvalid0, rdata, want);
        end
        idle(1);
    endtask

    task automatic test_inflight_reset();
        do_reset();
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0, AW'(7), '0, 1'b0);
        rst_n = 1'b0;
        #1;
        total++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin
            bad++;
            $display("FAIL inflight_in_reset: rvalid0=%b rvalid1=%b, expected 0 0", rvalid0, rvalid1);
        end
        do_reset();
        idle(3);
        run_cycle(1'b1, 1'b0, AW'(3), '0, 1'b0, 1'b1, 1'b0, AW'(4), '0, 1'b0);
        total++;
        if (obs_g !== 0) begin
            bad++;
            $display("FAIL post_reset_rr: granted %0d, expected 0", obs_g);
        end
        idle(2);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 15))
            0:       return AW'(DEPTH - 1);
            1:       return AW'(DEPTH);
            2:       return AW'(WORDS - 1);
            default: return AW'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            run_cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, pick_addr(), DW'($urandom),
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, pick_addr(), DW'($urandom),
                      ($urandom_range(0, 3) == 0));
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_alternate();
        test_lock();
        test_raw();
        test_bounds();
        test_inflight_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default `DATA_WIDTH, word width of the shared RAM port.
REQ-002 Parameter ADDRESS_WIDTH, default `ADDRESS_WIDTH (12), RAM address width.
REQ-003 Parameter DEPTH, default `DEPTH (2500), number of valid RAM words.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Ports req0/req1  input  1  requester k has a valid access pending.
REQ-007 Ports we0/we1  input  1  requester k access is a write (1) or read (0).
REQ-008 Ports addr0/addr1  input  ADDRESS_WIDTH  requester k word address.
REQ-009 Ports wdata0/wdata1  input  DATA_WIDTH  requester k write data.
REQ-010 Ports lock0/lock1  input  1  requester k holds ownership after its current grant.
REQ-011 Ports gnt0/gnt1  output  1  combinational; access accepted this cycle.
REQ-012 Ports rvalid0/rvalid1  output  1  read data for requester k valid on rdata.
REQ-013 Port rdata  output  DATA_WIDTH  read return data, shared by both requesters.
REQ-014 Ports ram_addr, ram_wdata, ram_we  output  ADDRESS_WIDTH/DATA_WIDTH/1  registered drive to the RAM port.
REQ-015 Port ram_rdata  input  DATA_WIDTH  RAM data_out; 1-cycle read latency.

Function
REQ-016 Per cycle, at most one of gnt0/gnt1 SHALL be high; a transfer occurs when reqk and gntk are both high.
REQ-017 FSM states: IDLE, OWN0, OWN1. In IDLE, a single requester SHALL be granted; with both requesting, the requester not granted last SHALL win (round-robin).
REQ-018 A granted transfer with lockk=1 SHALL move the FSM to OWNk; in OWNk, only requester k SHALL be granted; OWNk SHALL return to IDLE on the first cycle with reqk=1 and lockk=0 (granted) or with reqk=0.
REQ-019 Accepted access at edge T SHALL appear on ram_addr/ram_wdata/ram_we during T+1; ram_we SHALL be high exactly one cycle per accepted write.
REQ-020 Accepted read at edge T SHALL assert rvalidk for exactly one cycle at T+2, with rdata = ram_rdata; writes SHALL produce no rvalid.
REQ-021 Back-to-back accepted accesses SHALL sustain one per cycle with no bubbles; read returns SHALL keep acceptance order via a 2-stage requester tag pipeline.
REQ-022 Read after write to the same address in consecutive cycles SHALL return the newly written data.
REQ-023 When no access is accepted, ram_we SHALL be 0 and ram_addr SHALL hold its previous value.

Reset
REQ-024 rst_n=0 SHALL force: FSM=IDLE, round-robin last-grant=1 (requester 0 wins first), ram_we=0, ram_addr=0, ram_wdata=0, rvalid0/1=0, tag pipeline cleared.
REQ-025 gnt0/gnt1 SHALL be 0 while rst_n=0.
REQ-026 Reads in flight at reset SHALL be discarded; no rvalid SHALL follow reset release for them.

Configuration
REQ-027 Macro RAM_ARB_BOUNDS_CHECK_EN defined: an accepted access with addr >= DEPTH SHALL be granted, SHALL NOT drive ram_we, and for reads SHALL return rvalidk at T+2 with rdata=0; output err (1 bit, added port) SHALL pulse at T+1.
REQ-028 Macro undefined: no err port; all addresses SHALL pass to the RAM unchanged.

Structure
REQ-029 FSM state enumeration and requester-tag width SHALL live in the shared package alongside DATA_WIDTH/ADDRESS_WIDTH/DEPTH.
REQ-030 Round-robin grant logic SHALL be one sub-module, rr_arb2, reused by other shared-resource arbiters.

Verification
REQ-031 Reset, then req0 read addr 5 (mem[5]=0x1234) -> gnt0 same cycle, ram_addr=5 at T+1, rvalid0=1 and rdata=0x1234 at T+2.
REQ-032 req0 and req1 both held 4 cycles -> grants alternate 0,1,0,1.
REQ-033 req0 with lock0=1 for 3 cycles while req1=1 -> gnt0 3 consecutive cycles, gnt1 on the 4th after lock0 drops.
REQ-034 req1 write addr 10 data 0xBEEF, next cycle req1 read addr 10 -> rvalid1 with rdata=0xBEEF two cycles after read grant.
REQ-035 With RAM_ARB_BOUNDS_CHECK_EN, req0 write addr 2600 -> gnt0=1, ram_we stays 0, err pulses one cycle; a following read of addr 2600 returns rdata=0.
REQ-036 rst_n dropped one cycle after a read grant -> no rvalid after release; first post-reset contention grants requester 0.
